// File: rtl/gb_dma_pkg.sv
// Shared definitions for the Game Boy OAM DMA controller: state encoding,
// fixed register/region addresses and the echo-RAM source remap.
package gb_dma_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_XFER = 2'd2
  } dma_state_e;

  localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
  localparam logic [15:0] HRAM_IO_BASE = 16'hFF00;
  localparam logic [7:0]  ECHO_BASE    = 8'hE0;

  // Pages E0..FF mirror C0..DF, so the copy reads the underlying WRAM page.
  function automatic logic [7:0] remap_src(input logic [7:0] src);
    return (src < ECHO_BASE) ? src : (src - 8'h20);
  endfunction

endpackage

// File: rtl/gb_oam_dma.sv
// OAM DMA controller and CPU/memory bus arbiter. A CPU write to FF46 copies
// DMA_LEN bytes from page {src,00} into OAM, one byte per M_CYCLE cen ticks,
// while the memory bus is owned by the DMA and CPU accesses below FF00 are fenced.
module gb_oam_dma
  import gb_dma_pkg::*;
#(
  parameter int M_CYCLE = 4,
  parameter int DMA_LEN = 160
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cen,
  input  logic [15:0] cpu_a,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_mreq_n,
  input  logic        cpu_rd_n,
  input  logic        cpu_wr_n,
  output logic [7:0]  cpu_din,
  output logic [15:0] mem_a,
  output logic [7:0]  mem_dout,
  output logic        mem_mreq_n,
  output logic        mem_rd_n,
  output logic        mem_wr_n,
  input  logic [7:0]  mem_din,
  output logic [7:0]  oam_a,
  output logic [7:0]  oam_d,
  output logic        oam_we,
  output logic        dma_active
);

  localparam int             T_W    = (M_CYCLE > 1) ? $clog2(M_CYCLE) : 1;
  localparam logic [T_W-1:0] T_LAST = T_W'(M_CYCLE - 1);
  localparam logic [7:0]     N_LAST = 8'(DMA_LEN - 1);

  dma_state_e     state_reg, state_next;
  logic [T_W-1:0] t_reg, t_next;
  logic [7:0]     n_reg, n_next;
  logic           restart_reg, restart_next;
  logic [7:0]     src_reg, src_next;
  logic           wr_n_prev_reg;
  logic [7:0]     oam_a_reg, oam_d_reg;
  logic           oam_we_reg;
  logic           byte_done;
  logic           launch;
  logic           cpu_low;
  logic [7:0]     hsrc;

  // One launch per falling edge of the CPU write strobe onto FF46.
  assign launch  = cen && wr_n_prev_reg && !cpu_wr_n && !cpu_mreq_n
                   && (cpu_a == DMA_REG_ADDR);
  assign cpu_low = (cpu_a < HRAM_IO_BASE);
  assign hsrc    = remap_src(src_reg);

  // The bus stays fenced through a restart ARM so the CPU never sees a gap.
  assign dma_active = (state_reg == ST_XFER) || ((state_reg == ST_ARM) && restart_reg);

  assign oam_a  = oam_a_reg;
  assign oam_d  = oam_d_reg;
  assign oam_we = oam_we_reg;

  // Next-state and counter logic; a launch takes priority over any tick work.
  always_comb begin
    state_next   = state_reg;
    t_next       = t_reg;
    n_next       = n_reg;
    restart_next = restart_reg;
    src_next     = src_reg;
    byte_done    = 1'b0;
    if (launch) begin
      src_next     = cpu_dout;
      state_next   = ST_ARM;
      t_next       = '0;
      n_next       = '0;
      restart_next = restart_reg || (state_reg == ST_XFER);
    end else if (cen) begin
      case (state_reg)
        ST_IDLE: begin
          t_next = '0;
        end
        ST_ARM: begin
          if (t_reg == T_LAST) begin
            state_next   = ST_XFER;
            t_next       = '0;
            n_next       = '0;
            restart_next = 1'b0;
          end else begin
            t_next = t_reg + T_W'(1);
          end
        end
        ST_XFER: begin
          if (t_reg == T_LAST) begin
            byte_done = 1'b1;
            t_next    = '0;
            if (n_reg == N_LAST) begin
              state_next   = ST_IDLE;
              n_next       = '0;
              restart_next = 1'b0;
            end else begin
              n_next = n_reg + 8'd1;
            end
          end else begin
            t_next = t_reg + T_W'(1);
          end
        end
        default: begin
          state_next   = ST_IDLE;
          t_next       = '0;
          n_next       = '0;
          restart_next = 1'b0;
        end
      endcase
    end
  end

  // State, counters, FF46 and the OAM write port; reset aborts any transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      t_reg         <= '0;
      n_reg         <= '0;
      restart_reg   <= 1'b0;
      src_reg       <= 8'h00;
      wr_n_prev_reg <= 1'b1;
      oam_a_reg     <= 8'h00;
      oam_d_reg     <= 8'h00;
      oam_we_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      t_reg       <= t_next;
      n_reg       <= n_next;
      restart_reg <= restart_next;
      src_reg     <= src_next;
      // byte_done is qualified by cen, so the strobe is a single clk wide.
      oam_we_reg  <= byte_done;
      if (cen) begin
        wr_n_prev_reg <= cpu_wr_n;
      end
      if (byte_done) begin
        oam_a_reg <= n_reg;
        oam_d_reg <= mem_din;
      end
    end
  end

  // Memory bus: CPU pass-through when idle, registered DMA read otherwise.
  always_comb begin
    mem_a      = cpu_a;
    mem_dout   = cpu_dout;
    mem_mreq_n = cpu_mreq_n;
    mem_rd_n   = cpu_rd_n;
    mem_wr_n   = cpu_wr_n;
    if (dma_active) begin
      mem_a      = {hsrc, n_reg};
      mem_mreq_n = 1'b0;
      mem_rd_n   = 1'b0;
      mem_wr_n   = 1'b1;
    end
  end

  // CPU read data: FF46 readback, open-bus 0xFF for fenced addresses, else memory.
  always_comb begin
    cpu_din = mem_din;
    if (cpu_a == DMA_REG_ADDR) begin
      cpu_din = src_reg;
    end else if (dma_active && cpu_low) begin
      cpu_din = 8'hFF;
    end
  end

endmodule

// File: tb/tb_gb_oam_dma.sv
// Self-checking bench for gb_oam_dma: every launch pushes the 160 expected OAM
// writes (index, data, source address, cen tick) and a monitor pops one per oam_we.
module tb_gb_oam_dma;

  localparam int M  = 4;
  localparam int NB = 160;

  logic        clk = 1'b0;
  logic        reset;
  logic        cen = 1'b0;
  logic [15:0] cpu_a;
  logic [7:0]  cpu_dout;
  logic        cpu_mreq_n, cpu_rd_n, cpu_wr_n;
  logic [7:0]  cpu_din;
  logic [15:0] mem_a;
  logic [7:0]  mem_dout;
  logic        mem_mreq_n, mem_rd_n, mem_wr_n;
  logic [7:0]  mem_din;
  logic [7:0]  oam_a, oam_d;
  logic        oam_we, dma_active;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  d;
    logic [15:0] addr;
    int          tick;
    bit          last;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   tick_cnt = 0;
  int   pulses   = 0;
  int   last_oam_a = -1;
  int   cen_rate = 1;
  int   cen_phase = 0;
  logic        prev_we = 1'b0;
  logic [15:0] prev_mem_a = 16'h0000;

  gb_oam_dma #(.M_CYCLE(M), .DMA_LEN(NB)) dut (
    .clk(clk), .reset(reset), .cen(cen),
    .cpu_a(cpu_a), .cpu_dout(cpu_dout),
    .cpu_mreq_n(cpu_mreq_n), .cpu_rd_n(cpu_rd_n), .cpu_wr_n(cpu_wr_n),
    .cpu_din(cpu_din),
    .mem_a(mem_a), .mem_dout(mem_dout),
    .mem_mreq_n(mem_mreq_n), .mem_rd_n(mem_rd_n), .mem_wr_n(mem_wr_n),
    .mem_din(mem_din),
    .oam_a(oam_a), .oam_d(oam_d), .oam_we(oam_we), .dma_active(dma_active)
  );

  // Memory contents: page C1 holds i^5A; other pages are offset so they differ.
  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    return a[7:0] ^ 8'h5A ^ (a[15:8] - 8'hC1);
  endfunction

  assign mem_din = mem_byte(mem_a);

  always #5 clk = ~clk;

  // cen is high for one clk out of every cen_rate.
  always @(negedge clk) begin
    cen_phase = (cen_phase + 1 >= cen_rate) ? 0 : cen_phase + 1;
    cen = (cen_phase == 0);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Monitor: count cen ticks, pop and compare one scoreboard entry per oam_we.
  always @(posedge clk) begin
    exp_t e;
    if (cen === 1'b1) tick_cnt++;
    #1;
    if (oam_we === 1'b1) begin
      pulses++;
      check("we_width", prev_we, 1'b0);
      check("sb_nonempty", sb.size() > 0, 1'b1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("oam_a", oam_a, e.a);
        check("oam_d", oam_d, e.d);
        check("rd_addr", prev_mem_a, e.addr);
        check("we_tick", tick_cnt, e.tick);
        check("active_at_we", dma_active, !e.last);
        $display("we #%0d oam_a=%0d oam_d=%02h src=%04h tick=%0d", pulses, oam_a, oam_d,
                 prev_mem_a, tick_cnt);
      end
      last_oam_a = oam_a;
    end
    prev_we    = oam_we;
    prev_mem_a = mem_a;
  end

  task automatic idle_bus();
    cpu_a      = 16'h1234;
    cpu_dout   = 8'h00;
    cpu_mreq_n = 1'b1;
    cpu_rd_n   = 1'b1;
    cpu_wr_n   = 1'b1;
  endtask

  // Wait for the next clk edge on which cen is high; returns its tick number.
  task automatic cen_edge(output int tk);
    bit seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(posedge clk);
      if (cen === 1'b1) seen = 1;
    end
    #2;
    check("cen_edge_timeout", seen, 1'b1);
    tk = tick_cnt;
  endtask

  // Write v to FF46 holding the strobe for hold cen ticks; queue the copy.
  task automatic launch(input logic [7:0] v, input int hold);
    int tk, dummy;
    logic [7:0]  page;
    logic [15:0] addr;
    exp_t e;
    @(negedge clk);
    cpu_a      = 16'hFF46;
    cpu_dout   = v;
    cpu_mreq_n = 1'b0;
    cpu_wr_n   = 1'b0;
    cen_edge(tk);
    sb.delete();
    last_oam_a = -1;
    page = (v >= 8'hE0) ? v - 8'h20 : v;
    for (int i = 0; i < NB; i++) begin
      addr   = {page, 8'(i)};
      e.a    = 8'(i);
      e.d    = mem_byte(addr);
      e.addr = addr;
      e.tick = tk + 2 * M + M * i;
      e.last = (i == NB - 1);
      sb.push_back(e);
    end
    $display("launch src=%02h at tick %0d hold=%0d", v, tk, hold);
    for (int i = 1; i < hold; i++) cen_edge(dummy);
    @(negedge clk);
    idle_bus();
  endtask

  task automatic wait_oam_a(input int target);
    for (int i = 0; i < 5000 && last_oam_a != target; i++) @(negedge clk);
    check("wait_oam_a", last_oam_a, target);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 10000 && (sb.size() != 0 || dma_active !== 1'b0); i++) @(negedge clk);
    check("drain_sb", sb.size(), 0);
    check("drain_active", dma_active, 1'b0);
    repeat (20) @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    reset = 1'b1;
    idle_bus();
    repeat (5) @(negedge clk);
    // Reset state and pass-through.
    check("rst_active", dma_active, 1'b0);
    check("rst_we", oam_we, 1'b0);
    check("rst_oam_a", oam_a, 8'h00);
    check("rst_oam_d", oam_d, 8'h00);
    check("rst_mem_a", mem_a, 16'h1234);
    check("rst_mreq", mem_mreq_n, 1'b1);
    cpu_a = 16'hFF46;
    #1 check("rst_src", cpu_din, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    cpu_a = 16'h4000; cpu_mreq_n = 1'b0; cpu_rd_n = 1'b0;
    #1;
    check("pass_din", cpu_din, mem_byte(16'h4000));
    check("pass_rd", mem_rd_n, 1'b0);
    check("pass_mem_a", mem_a, 16'h4000);
    @(negedge clk);
    idle_bus();

    // Basic copy from C100 plus CPU fencing while it runs.
    launch(8'hC1, 1);
    wait_oam_a(10);
    @(negedge clk);
    cpu_a = 16'h4000; cpu_mreq_n = 1'b0; cpu_rd_n = 1'b0;
    #1;
    check("fence_rd_din", cpu_din, 8'hFF);
    check("fence_mem_page", mem_a[15:8], 8'hC1);
    check("fence_mem_rd", mem_rd_n, 1'b0);
    @(negedge clk);
    cpu_rd_n = 1'b1; cpu_wr_n = 1'b0; cpu_a = 16'hC000; cpu_dout = 8'h77;
    #1;
    check("fence_wr_dropped", mem_wr_n, 1'b1);
    check("fence_wr_page", mem_a[15:8], 8'hC1);
    @(negedge clk);
    idle_bus();
    @(negedge clk);
    cpu_a = 16'hFF46; cpu_mreq_n = 1'b0; cpu_rd_n = 1'b0;
    #1 check("ff46_read", cpu_din, 8'hC1);
    @(negedge clk);
    idle_bus();
    wait_drain();
    #1 check("idle_pass_mem_a", mem_a, 16'h1234);

    // Echo source: FE reads DE00..DE9F.
    launch(8'hFE, 1);
    wait_drain();

    // Relaunch at byte 50: restart from C200 without dropping the bus.
    p0 = pulses;
    launch(8'hC1, 1);
    wait_oam_a(50);
    launch(8'hC2, 1);
    check("restart_active", dma_active, 1'b1);
    check("restart_mem_page", mem_a[15:8], 8'hC2);
    wait_drain();
    check("restart_pulses", pulses - p0, 51 + NB);

    // Reset at byte 80 aborts immediately.
    launch(8'hC1, 1);
    wait_oam_a(80);
    @(negedge clk);
    reset = 1'b1;
    sb.delete();
    p0 = pulses;
    @(posedge clk);
    #2;
    check("abort_we", oam_we, 1'b0);
    check("abort_active", dma_active, 1'b0);
    cpu_a = 16'hFF46;
    #1 check("abort_src", cpu_din, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    idle_bus();
    repeat (400) @(negedge clk);
    check("abort_no_pulses", pulses - p0, 0);

    // Slow cen and a long write strobe: one launch, timing scales with cen.
    cen_rate = 3;
    p0 = pulses;
    launch(8'hC3, 12);
    wait_drain();
    check("slow_pulses", pulses - p0, NB);
    check("total_pulses", pulses, NB + NB + (51 + NB) + 81 + NB);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/gb_oam_dma.md
# gb_oam_dma

OAM DMA controller and bus arbiter for the Game Boy core. It sits between the tv80s CPU bus and the external memory bus (ROM/VRAM/WRAM/cart). A CPU write to FF46 launches a 160-byte copy from page `{src,8'h00}` into OAM. While the copy runs, the controller owns the memory bus and fences CPU accesses below FF00.

## Interface
Parameters:
- `M_CYCLE`, default 4: `cen` ticks per DMA byte, one M-cycle.
- `DMA_LEN`, default 160: bytes per transfer.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high.
- `cen`  in  1  CPU clock enable. All state advances only on `cen`, except the `oam_we` pulse width.
- `cpu_a`  in  16  CPU address.
- `cpu_dout`  in  8  CPU write data.
- `cpu_mreq_n`, `cpu_rd_n`, `cpu_wr_n`  in  1 each  CPU strobes, active low.
- `cpu_din`  out  8  read data to the CPU `di`.
- `mem_a`  out  16  memory bus address.
- `mem_dout`  out  8  memory bus write data.
- `mem_mreq_n`, `mem_rd_n`, `mem_wr_n`  out  1 each  memory strobes, active low.
- `mem_din`  in  8  memory bus read data.
- `oam_a`  out  8  OAM write index.
- `oam_d`  out  8  OAM write data.
- `oam_we`  out  1  OAM write strobe.
- `dma_active`  out  1  high while OAM and the bus are owned by DMA.

## Operation
- Register FF46 (`src`, 8 bits) is written by the DMA launch and read back by CPU reads of FF46. Reset value 0x00.
- Launch event:
  - Condition: on a `cen` edge, the registered previous `cpu_wr_n` is 1 and the current value is 0, with `cpu_mreq_n`=0 and `cpu_a`=FF46.
  - Effect: one launch per write strobe. `src` is loaded with `cpu_dout`.
- Source remap: effective high byte `hsrc` is `src` if `src` < 0xE0, otherwise `src` − 0x20 (echo region). This arithmetic is 8-bit, with no wrap concerns.
- States:
  - IDLE: bus passes through. Launch → ARM.
  - ARM: tick counter `t` counts 0..M_CYCLE-1. At `t`=M_CYCLE-1 the state moves to XFER with `n`=0 and `t`=0. A launch during ARM reloads `src` and restarts ARM with `t`=0.
  - XFER: per byte `n` (0..DMA_LEN-1), `t` counts 0..M_CYCLE-1.
    - `mem_a`={hsrc,n}, `mem_mreq_n`=0, `mem_rd_n`=0, `mem_wr_n`=1.
    - At `t`=M_CYCLE-1 on `cen`: `oam_d`<=`mem_din`, `oam_a`<=n, and `oam_we` is high for exactly one `clk`.
    - After `n`=DMA_LEN-1 the state goes to IDLE; otherwise `n`++ and `t`=0.
    - A launch during XFER → ARM with `restart` flag set.
- `dma_active` = (state==XFER) or (state==ARM and `restart`). `restart` clears on entering XFER or IDLE.
- Bus mux:
  - When `dma_active`=0: `mem_*`=`cpu_*` combinationally.
  - When `dma_active`=1, for CPU accesses with `cpu_a` < FF00: writes are dropped and reads return 0xFF.
  - Addresses FF00–FFFF are decoded by the top-level and never forwarded to `mem_*` during DMA.
- `cpu_din` = `src` when `cpu_a`=FF46; 0xFF when `dma_active` and `cpu_a` < FF00; else `mem_din`.
- Reset:
  - State IDLE; `t`, `n`, `restart`, `src`, `oam_a`, `oam_d` all 0.
  - `oam_we`=0 and `dma_active`=0.
  - `mem_*` in pass-through.
  - The write-edge register resets to 1.
  - Reset mid-transfer aborts immediately. No further `oam_we` is issued.

## Timing
- Launch detected at `cen` edge E0, then ARM for M_CYCLE `cen` ticks.
- First `oam_we` occurs M_CYCLE·2 `cen` ticks after E0 (ARM plus byte 0). Last `oam_we` occurs (DMA_LEN+1)·M_CYCLE ticks after E0, i.e. 644 with defaults.
- `dma_active` rises on entry to XFER (or stays high on a restart). It falls on the same edge as the last `oam_we` assertion.
- `oam_a`/`oam_d` are registered and stable while `oam_we` is high.
- `mem_a` and the strobes are registered from state/counters, so they change only on `cen` edges.
- With `cen` held low, the controller freezes; `oam_we` never repeats.

## Structure
- Shared package `gb_dma_pkg` holds:
  - the state encoding (IDLE/ARM/XFER);
  - `DMA_REG_ADDR`=16'hFF46;
  - `HRAM_IO_BASE`=16'hFF00;
  - `ECHO_BASE`=8'hE0.
- Single module, with no sub-module. The launch edge detector is inline.

## Test plan
- Reset, then write 0xC1 to FF46; memory C100+i holds i^0x5A → 160 `oam_we` pulses, `oam_a`=0..159, `oam_d`=i^0x5A; first pulse 8 `cen` ticks after launch; `dma_active` low afterward.
- Write 0xFE to FF46 → `mem_a` sweeps DE00–DE9F.
- During XFER, CPU reads 0x4000 → `cpu_din`=0xFF. CPU writes 0xC000 → no `mem_wr_n` low. CPU reads FF46 → 0xC1.
- Write 0xC2 at byte 50 of a running DMA → `dma_active` stays high, ARM for 4 ticks, restart at `n`=0 from C200, 160 further pulses.
- Assert `reset` at byte 80 → next `clk` has `oam_we`=0 and `dma_active`=0, `src` reads 0x00, no further pulses.
- Hold `cpu_wr_n` low for 12 `cen` ticks on FF46 → exactly one launch. Toggle `cen` at 1/3 rate → timing scales and `oam_we` stays 1 `clk` wide.
